// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, occupancy count and
// registered full/empty/almost flags plus overflow/underflow pulses.
module sync_fifo #(
  parameter int DSIZE    = 8,
  parameter int ASIZE    = 4,
  parameter int AF_LEVEL = (1 << ASIZE) - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wen,
  input  logic [DSIZE-1:0] wdata,
  input  logic             ren,
  output logic [DSIZE-1:0] rdata,
  output logic             rvalid,
  output logic             full,
  output logic             empty,
  output logic             afull,
  output logic             aempty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam int             DEPTH   = 1 << ASIZE;
  localparam logic [ASIZE:0] AF_LVL  = (ASIZE+1)'(AF_LEVEL);
  localparam logic [ASIZE:0] AE_LVL  = (ASIZE+1)'(AE_LEVEL);
  localparam logic [ASIZE:0] PTR_ONE = (ASIZE+1)'(1);

  logic [DSIZE-1:0] mem_r [DEPTH];
  logic [ASIZE:0]   wptr_r, rptr_r, count_r;
  logic [ASIZE:0]   wptr_nxt_s, rptr_nxt_s, count_nxt_s;
  logic             wr_acc_s, rd_acc_s;
  logic             full_nxt_s, empty_nxt_s, afull_nxt_s, aempty_nxt_s;
  logic [DSIZE-1:0] rdata_r;
  logic             rvalid_r, full_r, empty_r, afull_r, aempty_r;
  logic             overflow_r, underflow_r;

  // acceptance decisions and next-state values, all from pre-edge flags
  always_comb begin
    wr_acc_s    = wen & ~full_r;
    rd_acc_s    = ren & ~empty_r;
    wptr_nxt_s  = wptr_r;
    rptr_nxt_s  = rptr_r;
    count_nxt_s = count_r;
    if (wr_acc_s) begin
      wptr_nxt_s = wptr_r + PTR_ONE;
    end else begin
      wptr_nxt_s = wptr_r;
    end
    if (rd_acc_s) begin
      rptr_nxt_s = rptr_r + PTR_ONE;
    end else begin
      rptr_nxt_s = rptr_r;
    end
    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_nxt_s = count_r + PTR_ONE;
      2'b01:   count_nxt_s = count_r - PTR_ONE;
      default: count_nxt_s = count_r;
    endcase
    // wrap bit distinguishes a full ring from an empty one
    full_nxt_s   = (wptr_nxt_s[ASIZE-1:0] == rptr_nxt_s[ASIZE-1:0]) &&
                   (wptr_nxt_s[ASIZE] != rptr_nxt_s[ASIZE]);
    empty_nxt_s  = (wptr_nxt_s == rptr_nxt_s);
    afull_nxt_s  = (count_nxt_s >= AF_LVL);
    aempty_nxt_s = (count_nxt_s <= AE_LVL);
  end

  // storage array write; contents deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_r[wptr_r[ASIZE-1:0]] <= wdata;
    end
  end

  // pointers, count, flags and read port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_r      <= '0;
      rptr_r      <= '0;
      count_r     <= '0;
      full_r      <= 1'b0;
      empty_r     <= 1'b1;
      afull_r     <= 1'b0;
      aempty_r    <= 1'b1;
      rdata_r     <= '0;
      rvalid_r    <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      wptr_r      <= wptr_nxt_s;
      rptr_r      <= rptr_nxt_s;
      count_r     <= count_nxt_s;
      full_r      <= full_nxt_s;
      empty_r     <= empty_nxt_s;
      afull_r     <= afull_nxt_s;
      aempty_r    <= aempty_nxt_s;
      rvalid_r    <= rd_acc_s;
      overflow_r  <= wen & full_r;
      underflow_r <= ren & empty_r;
      if (rd_acc_s) begin
        rdata_r <= mem_r[rptr_r[ASIZE-1:0]];
      end else begin
        rdata_r <= rdata_r;
      end
    end
  end

  assign rdata     = rdata_r;
  assign rvalid    = rvalid_r;
  assign full      = full_r;
  assign empty     = empty_r;
  assign afull     = afull_r;
  assign aempty    = aempty_r;
  assign count     = count_r;
  assign overflow  = overflow_r;
  assign underflow = underflow_r;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo (DEPTH=4, AF=3, AE=1): stimulus pushes expected
// read words into a queue, a negedge monitor pops and compares on rvalid.
module tb_sync_fifo;

  logic       clk;
  logic       rst_n;
  logic       wen;
  logic [7:0] wdata;
  logic       ren;
  logic [7:0] rdata;
  logic       rvalid;
  logic       full, empty, afull, aempty;
  logic [2:0] count;
  logic       overflow, underflow;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];   // words the monitor must see next, in order
  logic [7:0] mdl_q[$];   // words the bench believes are stored
  logic [7:0] last_rdata = 8'h00;

  sync_fifo #(.DSIZE(8), .ASIZE(2), .AF_LEVEL(3), .AE_LEVEL(1)) dut (
    .clk(clk), .rst_n(rst_n), .wen(wen), .wdata(wdata), .ren(ren),
    .rdata(rdata), .rvalid(rvalid), .full(full), .empty(empty),
    .afull(afull), .aempty(aempty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // read-data monitor: compares every rvalid word against the scoreboard
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst_n) begin
      last_rdata = 8'h00;
    end else if (rvalid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rvalid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("rdata", int'(rdata), int'(e));
      end
      last_rdata = rdata;
    end else begin
      chk("rdata_hold", int'(rdata), int'(last_rdata));
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_count"}, int'(count), 0);
    chk({tag, "_empty"}, int'(empty), 1);
    chk({tag, "_aempty"}, int'(aempty), 1);
    chk({tag, "_full"}, int'(full), 0);
    chk({tag, "_afull"}, int'(afull), 0);
    chk({tag, "_rdata"}, int'(rdata), 0);
    chk({tag, "_rvalid"}, int'(rvalid), 0);
    chk({tag, "_overflow"}, int'(overflow), 0);
    chk({tag, "_underflow"}, int'(underflow), 0);
  endtask

  // one clock of stimulus, called at a negedge; checks post-edge state
  task automatic cyc(input logic w, input logic [7:0] d, input logic r,
                     input int exp_cnt, input logic exp_ov, input logic exp_un);
    int  sz;
    logic exp_rv;
    wen   = w;
    wdata = d;
    ren   = r;
    @(posedge clk);
    sz     = mdl_q.size();
    exp_rv = r && (sz > 0);
    if (exp_rv) exp_q.push_back(mdl_q.pop_front());
    if (w && sz < 4) mdl_q.push_back(d);
    @(negedge clk);
    wen = 1'b0;
    ren = 1'b0;
    chk("count", int'(count), exp_cnt);
    chk("full", int'(full), int'(exp_cnt == 4));
    chk("empty", int'(empty), int'(exp_cnt == 0));
    chk("afull", int'(afull), int'(exp_cnt >= 3));
    chk("aempty", int'(aempty), int'(exp_cnt <= 1));
    chk("overflow", int'(overflow), int'(exp_ov));
    chk("underflow", int'(underflow), int'(exp_un));
    chk("rvalid", int'(rvalid), int'(exp_rv));
  endtask

  initial begin
    rst_n = 1'b0;
    wen   = 1'b0;
    ren   = 1'b0;
    wdata = 8'h00;
    @(negedge clk);
    @(negedge clk);
    chk_reset_vals("por");
    #2 rst_n = 1'b1;
    @(negedge clk);

    // fill in order, then overflow attempt at full
    cyc(1'b1, 8'h11, 1'b0, 1, 1'b0, 1'b0);
    cyc(1'b1, 8'h22, 1'b0, 2, 1'b0, 1'b0);
    cyc(1'b1, 8'h33, 1'b0, 3, 1'b0, 1'b0);
    cyc(1'b1, 8'h44, 1'b0, 4, 1'b0, 1'b0);
    cyc(1'b1, 8'h55, 1'b0, 4, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 4, 1'b0, 1'b0);
    // drain: 0x11..0x44, never 0x55
    cyc(1'b0, 8'h00, 1'b1, 3, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 2, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b0);
    // underflow at empty
    cyc(1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b0);

    // streaming at count=2 across several pointer wraps
    cyc(1'b1, 8'hA0, 1'b0, 1, 1'b0, 1'b0);
    cyc(1'b1, 8'hA1, 1'b0, 2, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 8'hB0 + 8'(i), 1'b1, 2, 1'b0, 1'b0);
    end
    cyc(1'b0, 8'h00, 1'b1, 1, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b0);

    // both requests at full, then both at empty
    cyc(1'b1, 8'hC0, 1'b0, 1, 1'b0, 1'b0);
    cyc(1'b1, 8'hC1, 1'b0, 2, 1'b0, 1'b0);
    cyc(1'b1, 8'hC2, 1'b0, 3, 1'b0, 1'b0);
    cyc(1'b1, 8'hC3, 1'b0, 4, 1'b0, 1'b0);
    cyc(1'b1, 8'hCC, 1'b1, 3, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 2, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b0);
    cyc(1'b1, 8'hDD, 1'b1, 1, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b0);

    // asynchronous reset mid-cycle with three words stored
    cyc(1'b1, 8'hE1, 1'b0, 1, 1'b0, 1'b0);
    cyc(1'b1, 8'hE2, 1'b0, 2, 1'b0, 1'b0);
    cyc(1'b1, 8'hE3, 1'b0, 3, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("async_rst");
    mdl_q.delete();
    chk("pending_reads_at_reset", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    cyc(1'b1, 8'hA5, 1'b0, 1, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b0);
    chk("last_read_word", int'(rdata), 8'hA5);
    chk("unconsumed_reads", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter DSIZE, default 8: data width in bits.
REQ-002 Parameter ASIZE, default 4: address width; depth DEPTH = 2^ASIZE entries.
REQ-003 Parameter AF_LEVEL, default DEPTH-2: almost-full threshold in entries; legal range 1..DEPTH.
REQ-004 Parameter AE_LEVEL, default 2: almost-empty threshold in entries; legal range 0..DEPTH-1.
REQ-005 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-006 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-007 Port wen, input, 1: write request.
REQ-008 Port wdata, input, DSIZE: write data, sampled with wen.
REQ-009 Port ren, input, 1: read request.
REQ-010 Port rdata, output, DSIZE: registered read data.
REQ-011 Port rvalid, output, 1: one-cycle pulse marking new rdata.
REQ-012 Port full, output, 1: FIFO holds DEPTH entries.
REQ-013 Port empty, output, 1: FIFO holds 0 entries.
REQ-014 Port afull, output, 1: count >= AF_LEVEL.
REQ-015 Port aempty, output, 1: count <= AE_LEVEL.
REQ-016 Port count, output, ASIZE+1: current number of stored entries.
REQ-017 Port overflow, output, 1: one-cycle pulse for a rejected write.
REQ-018 Port underflow, output, 1: one-cycle pulse for a rejected read.

Function
REQ-019 Storage: internal DSIZE x DEPTH array, written on clk; array contents are not reset.
REQ-020 Write and read pointers: ASIZE+1 bits each; the low ASIZE bits address the array; the MSB is a wrap bit; increment modulo 2^(ASIZE+1).
REQ-021 Write accept: wen=1 and full=0 -> store wdata at wptr, wptr+1, on the same edge.
REQ-022 Read accept: ren=1 and empty=0 -> rdata <= mem[rptr], rvalid=1 for the next cycle, rptr+1.
REQ-023 Read latency: exactly 1 clk from the accepted ren edge to rdata/rvalid.
REQ-024 rvalid=0 in every cycle with no accepted read; rdata holds its last value.
REQ-025 Count update: +1 on write only, -1 on read only, unchanged on both or neither; count is never outside 0..DEPTH.
REQ-026 Simultaneous wen and ren: each is accepted independently per REQ-021/022, using the flags present before the edge.
REQ-027 At full with wen=1 and ren=1: read accepted, write rejected, overflow pulses, count becomes DEPTH-1.
REQ-028 At empty with wen=1 and ren=1: write accepted, read rejected, underflow pulses, count becomes 1; no write-through to rdata.
REQ-029 full, empty, afull and aempty are registered and consistent with count in the same cycle; no combinational path from wen/ren to any output.
REQ-030 overflow=1 in the cycle after an edge where wen=1 and full=1; otherwise 0.
REQ-031 underflow=1 in the cycle after an edge where ren=1 and empty=1; otherwise 0.
REQ-032 Rejected requests do not change the pointers, count, array or rdata.
REQ-033 Pointer wrap: FIFO order is preserved across any number of wraps; full = pointer low bits equal and wrap bits differ; empty = pointers equal.

Reset
REQ-034 rst_n=0 asynchronously forces: wptr=0, rptr=0, count=0, empty=1, aempty=1, full=0, afull=0, rdata=0, rvalid=0, overflow=0, underflow=0.
REQ-035 Reset mid-operation discards all stored entries; the first accepted write after release is the first word read.
REQ-036 Reset release is synchronous to clk; requests on the first edge after release are processed normally.

Verification (DSIZE=8, ASIZE=2, AF_LEVEL=3, AE_LEVEL=1)
REQ-037 Write 0x11,0x22,0x33,0x44 -> count 1..4, afull at count 3, full at count 4, aempty cleared at count 2; then read 4 times -> rdata 0x11,0x22,0x33,0x44, each 1 cycle after ren, with rvalid pulses; empty=1 at the end.
REQ-038 At full, wen=1 with wdata=0x55 -> overflow pulses once, count stays 4, and the later read sequence contains no 0x55.
REQ-039 At empty, ren=1 -> underflow pulses once, rvalid=0, rdata unchanged, count stays 0.
REQ-040 Continuous simultaneous wen/ren for 20 cycles at count=2 -> count stays 2; data is read in write order across at least 4 pointer wraps.
REQ-041 Both requests at full, and then both at empty -> behaviour exactly per REQ-027 and REQ-028.
REQ-042 Assert rst_n=0 mid-clock with count=3 -> all outputs take their REQ-034 values immediately; after release, write 0xA5 then read -> rdata=0xA5.
